// File: rtl/conv_ctrl_pkg.sv
// ============================================================================
//  Module      : conv_ctrl_pkg
//  Description : Shared types and constants for the convolution frame
//                sequencer: FSM state encoding, compute-mode codes and the
//                default watchdog limit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_ctrl_pkg;

  // Sequencer states; width fixed at 3 bits
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STORE   = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_WAIT_CD = 3'd3,
    ST_NEXT    = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

  // Compute-mode encodings as presented on the mode input
  localparam logic [1:0] MODE_SINGLE  = 2'b00;
  localparam logic [1:0] MODE_SA3     = 2'b01;
  localparam logic [1:0] MODE_SA2     = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  // Default watchdog limit in cycles for any wait state
  localparam int TIMEOUT_CYC_DEFAULT = 256;

endpackage : conv_ctrl_pkg

`default_nettype wire

// File: rtl/conv_wdog.sv
// ============================================================================
//  Module      : conv_wdog
//  Description : Wait-state watchdog. Counts cycles while enabled, clears on
//                request, and flags expiry when the count reaches the limit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_wdog #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over counting
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count is 0 on the first cycle in a state, so TIMEOUT_CYC-1 marks the
  // last allowed cycle; the FSM leaves on that edge.
  assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule : conv_wdog

`default_nettype wire

// File: rtl/conv_sequencer.sv
// ============================================================================
//  Module      : conv_sequencer
//  Description : Frame-level controller for the 4x4-tile convolution engine.
//                Per tile it runs STORE, then the compute phase selected by
//                the latched mode, then waits for computation_done, for
//                NUM_TILES tiles, and reports frame completion.
//                Optional watchdog: define CONV_SEQ_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int NUM_TILES = 4,
  parameter int TIDX_W    = 2
`ifdef CONV_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              frame_done,
  output logic              mode_err,
  output logic              timeout_err,
  output logic [TIDX_W-1:0] tile_idx,
  output logic              active_store,
  output logic              active_single,
  output logic              active_sa3,
  output logic              active_sa2,
  input  logic              done_store,
  input  logic              done_single,
  input  logic              done_sa3,
  input  logic              done_sa2,
  input  logic              computation_done
);

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [TIDX_W-1:0] tile_idx_q, tile_idx_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              mode_err_q, mode_err_d;
  logic              act_store_q, act_store_d;
  logic              act_single_q, act_single_d;
  logic              act_sa3_q, act_sa3_d;
  logic              act_sa2_q, act_sa2_d;

  logic              start_ok;
  logic              sel_done;
  logic              last_tile;
  logic              wd_expire;

  assign start_ok  = start && (mode != MODE_ILLEGAL);
  assign last_tile = (tile_idx_q == TIDX_W'(NUM_TILES - 1));

  // Only the done matching the latched mode can end the compute phase
  always_comb begin
    case (mode_q)
      MODE_SINGLE: sel_done = done_single;
      MODE_SA3:    sel_done = done_sa3;
      MODE_SA2:    sel_done = done_sa2;
      default:     sel_done = 1'b0;
    endcase
  end

`ifdef CONV_SEQ_TIMEOUT_EN
  logic wd_clr;
  logic wd_en;
  logic timeout_err_q, timeout_err_d;

  // Any state change restarts the count; only the wait states count
  assign wd_clr = (state_d != state_q);
  assign wd_en  = (state_q == ST_STORE) || (state_q == ST_COMPUTE) ||
                  (state_q == ST_WAIT_CD);

  conv_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  // Wait states never return to IDLE on their own, so IDLE here means expiry
  assign timeout_err_d = wd_expire && (state_d == ST_IDLE);

  // Watchdog error pulse register
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state logic; a done already present on state entry is taken at once
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_ok)         state_d = ST_STORE;
      ST_STORE:   if (done_store)       state_d = ST_COMPUTE;
      ST_COMPUTE: if (sel_done)         state_d = ST_WAIT_CD;
      ST_WAIT_CD: if (computation_done) state_d = ST_NEXT;
      ST_NEXT:    state_d = last_tile ? ST_FIN : ST_STORE;
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // A done arriving on the expiry cycle still lets the tile progress
    if (wd_expire && (state_d == state_q)) begin
      state_d = ST_IDLE;
    end
  end

  // Output next values: outputs are registered copies of the next state
  always_comb begin
    act_store_d  = (state_d == ST_STORE);
    act_single_d = (state_d == ST_COMPUTE) && (mode_q == MODE_SINGLE);
    act_sa3_d    = (state_d == ST_COMPUTE) && (mode_q == MODE_SA3);
    act_sa2_d    = (state_d == ST_COMPUTE) && (mode_q == MODE_SA2);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_FIN);
    mode_err_d   = (state_q == ST_IDLE) && start && (mode == MODE_ILLEGAL);
    mode_d       = mode_q;
    tile_idx_d   = tile_idx_q;
    if ((state_q == ST_IDLE) && start_ok) begin
      mode_d     = mode;
      tile_idx_d = '0;
    end else if ((state_q == ST_NEXT) && !last_tile) begin
      tile_idx_d = tile_idx_q + TIDX_W'(1);
    end
  end

  // State, latched mode, tile counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_SINGLE;
      tile_idx_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      mode_err_q   <= 1'b0;
      act_store_q  <= 1'b0;
      act_single_q <= 1'b0;
      act_sa3_q    <= 1'b0;
      act_sa2_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      tile_idx_q   <= tile_idx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      mode_err_q   <= mode_err_d;
      act_store_q  <= act_store_d;
      act_single_q <= act_single_d;
      act_sa3_q    <= act_sa3_d;
      act_sa2_q    <= act_sa2_d;
    end
  end

  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign mode_err      = mode_err_q;
  assign tile_idx      = tile_idx_q;
  assign active_store  = act_store_q;
  assign active_single = act_single_q;
  assign active_sa3    = act_sa3_q;
  assign active_sa2    = act_sa2_q;

endmodule : conv_sequencer

`default_nettype wire

// File: tb/tb_conv_sequencer.sv
// ============================================================================
//  Module      : tb_conv_sequencer
//  Description : Directed self-checking bench for conv_sequencer
//                (NUM_TILES=4; watchdog scenario when CONV_SEQ_TIMEOUT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       busy, frame_done, mode_err, timeout_err;
  logic [1:0] tile_idx;
  logic       active_store, active_single, active_sa3, active_sa2;
  logic       done_store = 1'b0;
  logic       done_single = 1'b0;
  logic       done_sa3 = 1'b0;
  logic       done_sa2 = 1'b0;
  logic       computation_done = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int fd_cnt = 0;

  logic [3:0] act;
  assign act = {active_store, active_single, active_sa3, active_sa2};

  conv_sequencer #(
    .NUM_TILES (4),
    .TIDX_W    (2)
`ifdef CONV_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYC (16)
`endif
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .mode             (mode),
    .busy             (busy),
    .frame_done       (frame_done),
    .mode_err         (mode_err),
    .timeout_err      (timeout_err),
    .tile_idx         (tile_idx),
    .active_store     (active_store),
    .active_single    (active_single),
    .active_sa3       (active_sa3),
    .active_sa2       (active_sa2),
    .done_store       (done_store),
    .done_single      (done_single),
    .done_sa3         (done_sa3),
    .done_sa2         (done_sa2),
    .computation_done (computation_done)
  );

  always #5 clk = ~clk;

  // Count frame_done pulses away from the active edge
  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({busy, frame_done, mode_err, timeout_err, tile_idx, act} !== 10'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b expected 0", {busy, frame_done, mode_err, timeout_err, tile_idx, act});
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({busy, act} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_release_idle: got %b expected 0", {busy, act});
    end
  endtask

  // Full frame, every done answered 2 cycles after its phase starts, with
  // foreign done pulses injected that must be ignored
  task automatic test_frame(input logic [1:0] m);
    logic [3:0] cv;
    int fd0;
    fd0 = fd_cnt;
    cv  = (m == 2'b00) ? 4'b0100 : (m == 2'b01) ? 4'b0010 : 4'b0001;
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
    mode  = 2'b11;
    for (int t = 0; t < 4; t++) begin
      n_checks++;
      if (act !== 4'b1000 || tile_idx !== 2'(t) || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL frame%0d_store_entry t%0d: act=%b idx=%0d busy=%b expected 1000/%0d/1", m, t, act, tile_idx, busy, t);
      end
      repeat (2) tick();
      n_checks++;
      if (act !== 4'b1000) begin
        n_errors++;
        $display("FAIL frame%0d_store_hold t%0d: act=%b expected 1000", m, t, act);
      end
      done_store = 1'b1;
      if (m != 2'b00) done_single = 1'b1;
      tick();
      done_store = 1'b0;
      if (m == 2'b00) done_sa3 = 1'b1;
      n_checks++;
      if (act !== cv) begin
        n_errors++;
        $display("FAIL frame%0d_compute_entry t%0d: act=%b expected %b", m, t, act, cv);
      end
      repeat (2) tick();
      n_checks++;
      if (act !== cv) begin
        n_errors++;
        $display("FAIL frame%0d_foreign_done t%0d: act=%b expected %b", m, t, act, cv);
      end
      done_single = 1'b0;
      done_sa3    = 1'b0;
      case (m)
        2'b00:   done_single = 1'b1;
        2'b01:   done_sa3 = 1'b1;
        default: done_sa2 = 1'b1;
      endcase
      tick();
      done_single = 1'b0;
      done_sa3    = 1'b0;
      done_sa2    = 1'b0;
      n_checks++;
      if (act !== 4'b0000 || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL frame%0d_wait_cd t%0d: act=%b busy=%b expected 0000/1", m, t, act, busy);
      end
      repeat (2) tick();
      computation_done = 1'b1;
      tick();
      computation_done = 1'b0;
      n_checks++;
      if (act !== 4'b0000 || frame_done !== 1'b0) begin
        n_errors++;
        $display("FAIL frame%0d_next t%0d: act=%b fd=%b expected 0000/0", m, t, act, frame_done);
      end
      tick();
    end
    n_checks++;
    if (frame_done !== 1'b1 || busy !== 1'b1 || tile_idx !== 2'd3) begin
      n_errors++;
      $display("FAIL frame%0d_fin: fd=%b busy=%b idx=%0d expected 1/1/3", m, frame_done, busy, tile_idx);
    end
    tick();
    n_checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || tile_idx !== 2'd3 || act !== 4'b0000) begin
      n_errors++;
      $display("FAIL frame%0d_idle: fd=%b busy=%b idx=%0d act=%b expected 0/0/3/0000", m, frame_done, busy, tile_idx, act);
    end
    n_checks++;
    if (fd_cnt - fd0 !== 1) begin
      n_errors++;
      $display("FAIL frame%0d_fd_count: got %0d expected 1", m, fd_cnt - fd0);
    end
  endtask

  task automatic test_mode_err();
    start = 1'b1;
    mode  = 2'b11;
    tick();
    start = 1'b0;
    mode  = 2'b00;
    n_checks++;
    if (mode_err !== 1'b1 || busy !== 1'b0 || act !== 4'b0000) begin
      n_errors++;
      $display("FAIL mode_err_pulse: err=%b busy=%b act=%b expected 1/0/0000", mode_err, busy, act);
    end
    tick();
    n_checks++;
    if (mode_err !== 1'b0 || busy !== 1'b0 || act !== 4'b0000) begin
      n_errors++;
      $display("FAIL mode_err_after: err=%b busy=%b act=%b expected 0/0/0000", mode_err, busy, act);
    end
  endtask

  // done_store held high all frame; start (with another mode) pulsed in STORE
  task automatic test_back_to_back();
    int fd0;
    fd0 = fd_cnt;
    done_store = 1'b1;
    start = 1'b1;
    mode  = 2'b00;
    tick();
    for (int t = 0; t < 4; t++) begin
      start = 1'b1;
      mode  = 2'b01;
      n_checks++;
      if (act !== 4'b1000 || tile_idx !== 2'(t)) begin
        n_errors++;
        $display("FAIL b2b_store t%0d: act=%b idx=%0d expected 1000/%0d", t, act, tile_idx, t);
      end
      tick();
      start = 1'b0;
      n_checks++;
      if (act !== 4'b0100 || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_one_cycle_store t%0d: act=%b busy=%b expected 0100/1", t, act, busy);
      end
      done_single = 1'b1;
      tick();
      done_single = 1'b0;
      computation_done = 1'b1;
      tick();
      computation_done = 1'b0;
      tick();
    end
    n_checks++;
    if (frame_done !== 1'b1 || tile_idx !== 2'd3) begin
      n_errors++;
      $display("FAIL b2b_fin: fd=%b idx=%0d expected 1/3", frame_done, tile_idx);
    end
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || act !== 4'b0000 || fd_cnt - fd0 !== 1) begin
      n_errors++;
      $display("FAIL b2b_idle_ignores_done: busy=%b act=%b fd=%0d expected 0/0000/1", busy, act, fd_cnt - fd0);
    end
    done_store = 1'b0;
    mode = 2'b00;
  endtask

  task automatic test_reset_mid();
    int fd0;
    fd0 = fd_cnt;
    start = 1'b1;
    mode  = 2'b10;
    tick();
    start = 1'b0;
    for (int t = 0; t < 2; t++) begin
      done_store = 1'b1;  tick(); done_store = 1'b0;
      done_sa2 = 1'b1;    tick(); done_sa2 = 1'b0;
      computation_done = 1'b1; tick(); computation_done = 1'b0;
      tick();
    end
    done_store = 1'b1;
    tick();
    done_store = 1'b0;
    n_checks++;
    if (act !== 4'b0001 || tile_idx !== 2'd2) begin
      n_errors++;
      $display("FAIL rstmid_compute_t2: act=%b idx=%0d expected 0001/2", act, tile_idx);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({busy, frame_done, mode_err, timeout_err, tile_idx, act} !== 10'b0) begin
      n_errors++;
      $display("FAIL rstmid_outputs: got %b expected 0", {busy, frame_done, mode_err, timeout_err, tile_idx, act});
    end
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b0 || act !== 4'b0000 || fd_cnt != fd0) begin
      n_errors++;
      $display("FAIL rstmid_quiet: busy=%b act=%b fd=%0d expected 0/0000/0", busy, act, fd_cnt - fd0);
    end
  endtask

`ifdef CONV_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    int fd0;
    fd0 = fd_cnt;
    n = 0;
    start = 1'b1;
    mode  = 2'b00;
    tick();
    start = 1'b0;
    while (active_store === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    n_checks++;
    if (n !== 16) begin
      n_errors++;
      $display("FAIL timeout_store_cycles: got %0d expected 16", n);
    end
    n_checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || act !== 4'b0000) begin
      n_errors++;
      $display("FAIL timeout_pulse: err=%b busy=%b act=%b expected 1/0/0000", timeout_err, busy, act);
    end
    tick();
    n_checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b0 || fd_cnt != fd0) begin
      n_errors++;
      $display("FAIL timeout_after: err=%b busy=%b fd=%0d expected 0/0/0", timeout_err, busy, fd_cnt - fd0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame(2'b00);
    test_frame(2'b01);
    test_frame(2'b10);
    test_mode_err();
    test_back_to_back();
    test_reset_mid();
    test_frame(2'b01);
`ifdef CONV_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "bench time limit");
  end

endmodule : tb_conv_sequencer

`default_nettype wire
